// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus for mem_port_arbiter.
// The master modport is the arbiter's view; slave is the environment (requesters + memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_done_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_done_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_done_o,
    output d_rdata_o, d_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_done_o,
    input  d_rdata_o, d_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port; data has fixed priority,
// every access is bounded by a wait-cycle timeout that raises a sticky error.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.master  bus,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;
  // Abort fires on the cycle whose missing ack would bring the counter to TIMEOUT.
  localparam logic [7:0]        LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       d_grant;
  logic       if_grant;
  logic       abort;

  // A port whose done pulse is currently out is not re-sampled that cycle.
  assign d_grant  = bus.d_req_i  && !bus.d_done_o;
  assign if_grant = bus.if_req_i && !bus.if_done_o;
  assign abort    = !bus.mem_ack_i && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      busy_o          <= 1'b0;
      err_o           <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= ADDR_ZERO;
      bus.mem_wdata_o <= DATA_ZERO;
      bus.if_rdata_o  <= DATA_ZERO;
      bus.d_rdata_o   <= DATA_ZERO;
      bus.if_done_o   <= 1'b0;
      bus.d_done_o    <= 1'b0;
    end else begin
      bus.if_done_o <= 1'b0;
      bus.d_done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_grant) begin
            state           <= D_ACC;
            busy_o          <= 1'b1;
            wait_cnt        <= '0;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= bus.d_we_i;
            bus.mem_addr_o  <= bus.d_addr_i;
            bus.mem_wdata_o <= bus.d_wdata_i;
          end else if (if_grant) begin
            state           <= IF_ACC;
            busy_o          <= 1'b1;
            wait_cnt        <= '0;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= bus.if_addr_i;
            bus.mem_wdata_o <= DATA_ZERO;
          end
        end
        IF_ACC, D_ACC: begin
          if (!bus.mem_ack_i)
            wait_cnt <= wait_cnt + 8'd1;
          // Ack in the final wait cycle takes precedence over the abort.
          if (bus.mem_ack_i || abort) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            bus.mem_req_o <= 1'b0;
            if (abort)
              err_o <= 1'b1;
            if (state == IF_ACC) begin
              bus.if_done_o <= 1'b1;
              if (bus.mem_ack_i)
                bus.if_rdata_o <= bus.mem_rdata_i;
            end else begin
              bus.d_done_o <= 1'b1;
              if (bus.mem_ack_i && !bus.mem_we_o)
                bus.d_rdata_o <= bus.mem_rdata_i;
            end
          end
        end
        default: begin
          state         <= IDLE;
          busy_o        <= 1'b0;
          bus.mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, then randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state: last completed read data per port, sticky error.
  logic [15:0] m_if;
  logic [15:0] m_d;
  bit          m_err;

  typedef struct {
    bit          p;       // 0 fetch, 1 data
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          wt;      // cycles without ack before ack; >= TO means never
    logic [15:0] mdata;
    int          lat;     // negedges from request to done
    logic [15:0] e_if;
    logic [15:0] e_d;
    bit          e_err;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ctrl"}, 32'({bus.mem_req_o, bus.mem_we_o, busy, err, bus.if_done_o, bus.d_done_o}), 32'd0);
    chk({tag, " mem_bus"}, {bus.mem_addr_o, bus.mem_wdata_o}, 32'd0);
    chk({tag, " rdata"}, {bus.if_rdata_o, bus.d_rdata_o}, 32'd0);
  endtask

  task automatic access(input bit p, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int wt, input logic [15:0] mdata, input int e_lat,
                        input logic [15:0] e_if, input logic [15:0] e_d, input bit e_err,
                        input string tag);
    int          lat = 0;
    bit          stable_ok = 1'b1;
    bit          both = 1'b0;
    logic [15:0] e_wd = p ? wdata : 16'h0000;
    bit          e_we = p & we;
    if (p) begin
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = we;
      bus.d_addr_i  = addr;
      bus.d_wdata_i = wdata;
      bus.if_addr_i = 16'($urandom);
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
      bus.d_we_i    = 1'b1;
      bus.d_addr_i  = 16'($urandom);
      bus.d_wdata_i = 16'($urandom);
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 16'($urandom);
      if (c == 1) begin
        chk({tag, " req_up"}, 32'(bus.mem_req_o), 32'd1);
        chk({tag, " busy_up"}, 32'(busy), 32'd1);
      end
      if (bus.mem_req_o && (bus.mem_addr_o !== addr || bus.mem_we_o !== e_we || bus.mem_wdata_o !== e_wd))
        stable_ok = 1'b0;
      if (bus.if_done_o && bus.d_done_o)
        both = 1'b1;
      if (bus.if_done_o || bus.d_done_o) begin
        lat = c;
        chk({tag, " done_port"}, 32'(bus.d_done_o), 32'(p));
        chk({tag, " req_down"}, 32'({bus.mem_req_o, busy}), 32'd0);
        break;
      end
      if (c == 1) begin
        bus.if_addr_i = 16'($urandom);
        bus.d_addr_i  = 16'($urandom);
        bus.d_wdata_i = 16'($urandom);
        bus.d_we_i    = 1'($urandom);
      end
      if (c == wt + 1 && bus.mem_req_o) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mdata;
      end
    end
    bus.if_req_i  = 1'b0;
    bus.d_req_i   = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk({tag, " single_pulse"}, 32'({bus.if_done_o, bus.d_done_o, bus.mem_req_o}), 32'd0);
    chk({tag, " stable"}, 32'(stable_ok), 32'd1);
    chk({tag, " no_dual_done"}, 32'(both), 32'd0);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " if_rdata"}, 32'(bus.if_rdata_o), 32'(e_if));
    chk({tag, " d_rdata"}, 32'(bus.d_rdata_o), 32'(e_d));
    chk({tag, " err"}, 32'(err), 32'(e_err));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000,  2, 16'hA5C3,  4, 16'hA5C3, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 16'h8000, 16'h0000,  0, 16'h1111,  2, 16'hA5C3, 16'h1111, 1'b0};
    vt[2] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF,  3, 16'hDEAD,  5, 16'hA5C3, 16'h1111, 1'b0};
    vt[3] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 14, 16'h0F0F, 16, 16'h0F0F, 16'h1111, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'h4444, 16'h9999, 14, 16'h2222, 16, 16'h0F0F, 16'h2222, 1'b0};
    vt[5] = '{1'b0, 1'b0, 16'h0055, 16'h0000, 99, 16'h7777, 16, 16'h0F0F, 16'h2222, 1'b1};

    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = 0;

    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset_idle");

    // Directed table
    for (int i = 0; i < 6; i++)
      access(vt[i].p, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wt, vt[i].mdata, vt[i].lat,
             vt[i].e_if, vt[i].e_d, vt[i].e_err, $sformatf("vec%0d", i));

    // Ack while idle must not disturb anything
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'hCAFE;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_ack ctrl", 32'({bus.if_done_o, bus.d_done_o, bus.mem_req_o, busy}), 32'd0);
    chk("idle_ack rdata", {bus.if_rdata_o, bus.d_rdata_o}, {16'h0F0F, 16'h2222});

    // Simultaneous requests: data first, then fetch
    begin
      int          n = 0;
      bit          ord [2];
      bit          have_first = 0;
      bit          both = 0;
      logic [15:0] first_addr = 16'h0000;
      bus.if_req_i = 1; bus.if_addr_i = 16'h0020;
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 16'h8000;
      for (int c = 0; c < 20 && n < 2; c++) begin
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        if (bus.if_done_o && bus.d_done_o) both = 1;
        if (bus.d_done_o && n < 2) begin ord[n] = 1; n++; bus.d_req_i = 0; end
        if (bus.if_done_o && n < 2) begin ord[n] = 0; n++; bus.if_req_i = 0; end
        if (bus.mem_req_o) begin
          if (!have_first) begin first_addr = bus.mem_addr_o; have_first = 1; end
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = (bus.mem_addr_o == 16'h8000) ? 16'h5A5A : 16'h3C3C;
        end
      end
      bus.if_req_i = 0; bus.d_req_i = 0; bus.mem_ack_i = 0;
      @(negedge clk);
      chk("simul count", 32'(n), 32'd2);
      chk("simul order", 32'({ord[0], ord[1]}), 32'b10);
      chk("simul first_addr", 32'(first_addr), 32'h8000);
      chk("simul rdata", {bus.if_rdata_o, bus.d_rdata_o}, {16'h3C3C, 16'h5A5A});
      chk("simul no_dual_done", 32'(both), 32'd0);
      chk("simul idle_after", 32'(bus.mem_req_o), 32'd0);
    end

    // Back-to-back zero-wait fetches 0..3
    begin
      int pulses = 0, grants = 0;
      bit addr_ok = 1, bubble_ok = 1, prev_req = 0;
      bus.if_req_i = 1; bus.if_addr_i = 16'h0000;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        if (bus.mem_req_o && !prev_req) begin
          if (bus.mem_addr_o !== 16'(grants)) addr_ok = 0;
          grants++;
        end
        prev_req = bus.mem_req_o;
        if (bus.if_done_o) begin
          pulses++;
          if (busy || bus.mem_req_o) bubble_ok = 0;
          bus.if_req_i = 0;
        end else if (!bus.if_req_i && pulses < 4) begin
          bus.if_req_i  = 1;
          bus.if_addr_i = 16'(pulses);
        end
        if (bus.mem_req_o) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = 16'h0100 + bus.mem_addr_o;
        end
      end
      chk("b2b pulses", 32'(pulses), 32'd4);
      chk("b2b grants", 32'(grants), 32'd4);
      chk("b2b addr", 32'(addr_ok), 32'd1);
      chk("b2b bubble", 32'(bubble_ok), 32'd1);
      chk("b2b if_rdata", 32'(bus.if_rdata_o), 32'h0103);
      chk("err_sticky", 32'(err), 32'd1);
    end

    // Reset in the middle of an access
    begin
      bit spurious = 0;
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 16'h7777;
      repeat (3) @(negedge clk);
      chk("rst_mid req_before", 32'(bus.mem_req_o), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_mid");
      bus.d_req_i = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'hFFFF;
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (bus.if_done_o || bus.d_done_o || busy || bus.mem_req_o) spurious = 1;
        @(negedge clk);
      end
      chk("rst_mid late_ack", 32'(spurious), 32'd0);
      chk("rst_mid rdata", {bus.if_rdata_o, bus.d_rdata_o}, 32'd0);
    end

    // Randomized transactions against the model
    m_if = 16'h0000; m_d = 16'h0000; m_err = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bit          p     = 1'($urandom);
      bit          we    = p & 1'($urandom);
      logic [15:0] addr  = 16'($urandom);
      logic [15:0] wdata = 16'($urandom);
      int          wt    = $urandom_range(0, 17);
      logic [15:0] mdata = 16'($urandom);
      int          e_lat = ((wt + 1 < TO) ? wt + 1 : TO) + 1;
      bit          tout  = (wt >= TO);
      if (tout) m_err = 1'b1;
      else if (!p) m_if = mdata;
      else if (!we) m_d = mdata;
      access(p, we, addr, wdata, wt, mdata, e_lat, m_if, m_d, m_err, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
